// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file widths, the x0 address and the writeback entry type
// used by the writeback arbiter, the register file and the decoder.
package rf_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] X0_ADDR = '0;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;

  function automatic logic is_x0(input logic [REG_AW-1:0] addr);
    return addr == X0_ADDR;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: ALU and long-latency result inputs, register-file
// write port, pending-write hazard query and FIFO occupancy.
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
);

  // Handshakes: an lu transfer completes in any cycle where lu_valid and
  // lu_ready are both high; lu_ready never looks at lu_valid. The ALU path
  // has no ready: a result is consumed in every cycle alu_stall is low, and
  // while alu_stall is high upstream holds it unchanged.
  logic                    alu_valid;
  logic [REG_AW-1:0]       alu_waddr;
  logic [DATA_W-1:0]       alu_wdata;
  logic                    alu_stall;

  logic                    lu_valid;
  logic [REG_AW-1:0]       lu_waddr;
  logic [DATA_W-1:0]       lu_wdata;
  logic                    lu_ready;

  logic                    rf_wen;
  logic [REG_AW-1:0]       rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;

  logic [REG_AW-1:0]       raddr_a;
  logic [REG_AW-1:0]       raddr_b;
  logic                    pend_a;
  logic                    pend_b;

  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output alu_valid, alu_waddr, alu_wdata, lu_valid, lu_waddr, lu_wdata,
           raddr_a, raddr_b,
    input  alu_stall, lu_ready, rf_wen, rf_waddr, rf_wdata, pend_a, pend_b,
           fifo_count
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata, lu_valid, lu_waddr, lu_wdata,
           raddr_a, raddr_b,
    output alu_stall, lu_ready, rf_wen, rf_waddr, rf_wdata, pend_a, pend_b,
           fifo_count
  );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Long-latency result FIFO; exposes per-entry valid/waddr so the top level
// can answer pending-write hazard queries. Entry storage is not reset.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  wb_entry_t                     i_push_ent,
  input  logic                          i_pop,
  output logic [CW-1:0]                 o_count,
  output wb_entry_t                     o_head,
  output logic [DEPTH-1:0]              o_ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  o_ent_waddr
);

  wb_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (i_pop) begin
        r_rd_ptr          <= r_rd_ptr + PW'(1);
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (i_push) begin
        r_wr_ptr          <= r_wr_ptr + PW'(1);
        r_valid[r_wr_ptr] <= 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_ent;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_ent_waddr[i] = r_mem[i].waddr;
    end
  end

  assign o_count     = r_count;
  assign o_head      = r_mem[r_rd_ptr];
  assign o_ent_valid = r_valid;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU results normally win the single write
// port, long-latency results queue in wb_fifo and are force-drained on starvation.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_wb_arbiter_if.slave       bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]                w_count;
  wb_entry_t                    w_head;
  wb_entry_t                    w_push_ent;
  logic [DEPTH-1:0]             w_ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] w_ent_waddr;
  logic                         w_nonempty;
  logic                         w_lu_ready;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_stall;
  logic                         w_alu_win;
  logic                         w_rf_wen;
  logic [REG_AW-1:0]            w_rf_waddr;
  logic [DATA_W-1:0]            w_rf_wdata;
  logic                         w_hit_a;
  logic                         w_hit_b;
  logic [SW-1:0]                r_starve;

  assign w_nonempty = (w_count != '0);
  assign w_lu_ready = !rst && (w_count < CW'(DEPTH));
  assign w_push     = bus.lu_valid && w_lu_ready && !is_x0(bus.lu_waddr);
  assign w_push_ent = '{waddr: bus.lu_waddr, wdata: bus.lu_wdata};

  // A stall cycle hands the port to the FIFO head; ALU x0 writes also leave it free.
  assign w_stall   = !rst && w_nonempty && (r_starve == SW'(STARVE_MAX));
  assign w_alu_win = !rst && !w_stall && bus.alu_valid && !is_x0(bus.alu_waddr);
  assign w_pop     = !rst && w_nonempty && !w_alu_win;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_ent  (w_push_ent),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head),
    .o_ent_valid (w_ent_valid),
    .o_ent_waddr (w_ent_waddr)
  );

  always_comb begin
    w_rf_wen   = 1'b0;
    w_rf_waddr = '0;
    w_rf_wdata = '0;
    if (w_alu_win) begin
      w_rf_wen   = 1'b1;
      w_rf_waddr = bus.alu_waddr;
      w_rf_wdata = bus.alu_wdata;
    end else if (w_pop) begin
      w_rf_wen   = 1'b1;
      w_rf_waddr = w_head.waddr;
      w_rf_wdata = w_head.wdata;
    end
  end

  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && (w_ent_waddr[i] == bus.raddr_a)) w_hit_a = 1'b1;
      if (w_ent_valid[i] && (w_ent_waddr[i] == bus.raddr_b)) w_hit_b = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_pop) begin
      r_starve <= '0;
    end else if (w_nonempty && w_alu_win && (r_starve != SW'(STARVE_MAX))) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign bus.alu_stall  = w_stall;
  assign bus.lu_ready   = w_lu_ready;
  assign bus.rf_wen     = w_rf_wen;
  assign bus.rf_waddr   = w_rf_waddr;
  assign bus.rf_wdata   = w_rf_wdata;
  assign bus.pend_a     = !rst && !is_x0(bus.raddr_a) && w_hit_a;
  assign bus.pend_b     = !rst && !is_x0(bus.raddr_b) && w_hit_b;
  assign bus.fifo_count = w_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with a write-order
// scoreboard on the register-file port.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
  localparam int EW         = REG_AW + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_exp;

  rf_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
    bus.alu_valid = v;
    bus.alu_waddr = a;
    bus.alu_wdata = d;
  endtask

  task automatic drive_lu(input logic v, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
    bus.lu_valid = v;
    bus.lu_waddr = a;
    bus.lu_wdata = d;
  endtask

  task automatic drive_idle();
    drive_alu(1'b0, '0, '0);
    drive_lu(1'b0, '0, '0);
    bus.raddr_a = '0;
    bus.raddr_b = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (bus.rf_wen === 1'b1) begin
        mon_got = {bus.rf_waddr, bus.rf_wdata};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rf_write_unexpected: got x%0d=%h, expected no write",
                   bus.rf_waddr, bus.rf_wdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL rf_write: got x%0d=%h, expected x%0d=%h",
                     mon_got[EW-1:DATA_W], mon_got[DATA_W-1:0],
                     mon_exp[EW-1:DATA_W], mon_exp[DATA_W-1:0]);
          end
        end
      end else if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== '0 || bus.rf_wdata !== '0) begin
        n_fail++;
        $display("FAIL rf_idle_zero: got wen=%b waddr=%0d wdata=%h, expected 0/0/0",
                 bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.raddr_a = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b, expected 0", bus.rf_wen); end
    n_checks++;
    if (bus.alu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, expected 0", bus.alu_stall); end
    n_checks++;
    if (bus.pend_a !== 1'b0 || bus.pend_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_pend: got %b%b, expected 00", bus.pend_a, bus.pend_b);
    end
    n_checks++;
    if (bus.fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d, expected 0", bus.fifo_count); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b, expected 1", bus.lu_ready); end
    n_checks++;
    if (bus.fifo_count !== '0) begin n_fail++; $display("FAIL reset_count_after: got %0d, expected 0", bus.fifo_count); end
  endtask

  task automatic test_lu_single();
    tick();
    bus.raddr_a = 5'd5;
    bus.raddr_b = 5'd6;
    drive_lu(1'b1, 5'd5, 32'h11);
    exp_q.push_back({5'd5, 32'h11});
    @(negedge clk);
    n_checks++;
    if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b, expected 1", bus.lu_ready); end
    n_checks++;
    if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got wen=%b, expected 0", bus.rf_wen); end
    tick();
    drive_lu(1'b0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd5) begin
      n_fail++; $display("FAIL single_write: got wen=%b x%0d, expected wen=1 x5", bus.rf_wen, bus.rf_waddr);
    end
    n_checks++;
    if (bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL single_count1: got %0d, expected 1", bus.fifo_count); end
    n_checks++;
    if (bus.pend_a !== 1'b1 || bus.pend_b !== 1'b0) begin
      n_fail++; $display("FAIL single_pend: got a=%b b=%b, expected a=1 b=0", bus.pend_a, bus.pend_b);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.fifo_count !== '0) begin n_fail++; $display("FAIL single_count0: got %0d, expected 0", bus.fifo_count); end
    n_checks++;
    if (bus.pend_a !== 1'b0) begin n_fail++; $display("FAIL single_pend_clear: got %b, expected 0", bus.pend_a); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d outstanding, expected 0", exp_q.size()); end
    drive_idle();
  endtask

  task automatic test_alu_priority();
    tick();
    drive_lu(1'b1, 5'd4, 32'hB);
    exp_q.push_back({5'd3, 32'hA});
    exp_q.push_back({5'd4, 32'hB});
    @(negedge clk);
    n_checks++;
    if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL prio_accept_nowrite: got %b, expected 0", bus.rf_wen); end
    tick();
    drive_lu(1'b0, '0, '0);
    drive_alu(1'b1, 5'd3, 32'hA);
    @(negedge clk);
    n_checks++;
    if (bus.rf_waddr !== 5'd3) begin n_fail++; $display("FAIL prio_alu_first: got x%0d, expected x3", bus.rf_waddr); end
    n_checks++;
    if (bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL prio_queued: got %0d, expected 1", bus.fifo_count); end
    tick();
    drive_alu(1'b0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.rf_waddr !== 5'd4) begin n_fail++; $display("FAIL prio_lu_next: got x%0d, expected x4", bus.rf_waddr); end
    tick();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || bus.fifo_count !== '0) begin
      n_fail++; $display("FAIL prio_drain: got %0d outstanding count=%0d, expected 0/0", exp_q.size(), bus.fifo_count);
    end
  endtask

  task automatic test_starve();
    logic [DATA_W-1:0] d, l0, l1;
    l0 = $urandom;
    l1 = $urandom;
    tick();
    d = $urandom;
    drive_alu(1'b1, 5'd1, d);
    drive_lu(1'b1, 5'd7, l0);
    exp_q.push_back({5'd1, d});
    @(negedge clk);
    n_checks++;
    if (bus.alu_stall !== 1'b0) begin n_fail++; $display("FAIL starve_c0: got %b, expected 0", bus.alu_stall); end
    for (int k = 1; k <= STARVE_MAX; k++) begin
      tick();
      drive_lu(1'b0, '0, '0);
      d = $urandom;
      drive_alu(1'b1, 5'd1, d);
      exp_q.push_back({5'd1, d});
      @(negedge clk);
      n_checks++;
      if (bus.alu_stall !== 1'b0) begin n_fail++; $display("FAIL starve_early c%0d: got %b, expected 0", k, bus.alu_stall); end
    end
    tick();
    d = $urandom;
    drive_alu(1'b1, 5'd1, d);
    exp_q.push_back({5'd7, l0});
    exp_q.push_back({5'd1, d});
    @(negedge clk);
    n_checks++;
    if (bus.alu_stall !== 1'b1) begin n_fail++; $display("FAIL starve_fire: got %b, expected 1", bus.alu_stall); end
    n_checks++;
    if (bus.rf_waddr !== 5'd7) begin n_fail++; $display("FAIL starve_head: got x%0d, expected x7", bus.rf_waddr); end
    tick();
    drive_lu(1'b1, 5'd8, l1);
    @(negedge clk);
    n_checks++;
    if (bus.alu_stall !== 1'b0 || bus.rf_waddr !== 5'd1) begin
      n_fail++; $display("FAIL starve_held_alu: got stall=%b x%0d, expected stall=0 x1", bus.alu_stall, bus.rf_waddr);
    end
    for (int k = 1; k <= STARVE_MAX; k++) begin
      tick();
      drive_lu(1'b0, '0, '0);
      d = $urandom;
      drive_alu(1'b1, 5'd1, d);
      exp_q.push_back({5'd1, d});
      @(negedge clk);
      n_checks++;
      if (bus.alu_stall !== 1'b0) begin n_fail++; $display("FAIL starve_cleared c%0d: got %b, expected 0", k, bus.alu_stall); end
    end
    tick();
    d = $urandom;
    drive_alu(1'b1, 5'd1, d);
    exp_q.push_back({5'd8, l1});
    exp_q.push_back({5'd1, d});
    @(negedge clk);
    n_checks++;
    if (bus.alu_stall !== 1'b1) begin n_fail++; $display("FAIL starve_fire2: got %b, expected 1", bus.alu_stall); end
    tick();
    @(negedge clk);
    tick();
    drive_alu(1'b0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || bus.fifo_count !== '0) begin
      n_fail++; $display("FAIL starve_drain: got %0d outstanding count=%0d, expected 0/0", exp_q.size(), bus.fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] a, l9, l10, l11;
    logic exp_ready [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    l9  = $urandom;
    l10 = $urandom;
    l11 = $urandom;
    bus.raddr_b = 5'd10;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) drive_lu(1'b1, 5'd9, l9);
      if (c == 1) drive_lu(1'b1, 5'd10, l10);
      if (c == 2) drive_lu(1'b1, 5'd11, l11);
      if (c != 6) begin
        a = $urandom;
        drive_alu(1'b1, 5'd2, a);
      end
      if (c == 5) exp_q.push_back({5'd9, l9});
      if (c <= 5) exp_q.push_back({5'd2, a});
      @(negedge clk);
      n_checks++;
      if (bus.lu_ready !== exp_ready[c]) begin
        n_fail++; $display("FAIL b2b_ready c%0d: got %b, expected %b", c, bus.lu_ready, exp_ready[c]);
      end
      if (c == 2) begin
        n_checks++;
        if (bus.fifo_count !== 2'd2 || bus.pend_b !== 1'b1) begin
          n_fail++; $display("FAIL b2b_full: got count=%0d pend_b=%b, expected 2/1", bus.fifo_count, bus.pend_b);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (bus.alu_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b, expected 1", bus.alu_stall); end
      end
    end
    tick();
    drive_lu(1'b0, '0, '0);
    drive_alu(1'b0, '0, '0);
    exp_q.push_back({5'd10, l10});
    exp_q.push_back({5'd11, l11});
    @(negedge clk);
    n_checks++;
    if (bus.fifo_count !== 2'd2) begin n_fail++; $display("FAIL b2b_third_in: got %0d, expected 2", bus.fifo_count); end
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || bus.fifo_count !== '0) begin
      n_fail++; $display("FAIL b2b_drain: got %0d outstanding count=%0d, expected 0/0", exp_q.size(), bus.fifo_count);
    end
    drive_idle();
  endtask

  task automatic test_x0();
    logic [DATA_W-1:0] l;
    l = $urandom;
    tick();
    bus.raddr_a = 5'd0;
    drive_lu(1'b1, 5'd0, 32'hFF);
    drive_alu(1'b1, 5'd0, $urandom);
    @(negedge clk);
    n_checks++;
    if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b, expected 1", bus.lu_ready); end
    n_checks++;
    if (bus.rf_wen !== 1'b0 || bus.pend_a !== 1'b0) begin
      n_fail++; $display("FAIL x0_no_write: got wen=%b pend_a=%b, expected 0/0", bus.rf_wen, bus.pend_a);
    end
    tick();
    drive_lu(1'b0, '0, '0);
    drive_alu(1'b0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.rf_wen !== 1'b0 || bus.fifo_count !== '0) begin
      n_fail++; $display("FAIL x0_discard: got wen=%b count=%0d, expected 0/0", bus.rf_wen, bus.fifo_count);
    end
    tick();
    drive_lu(1'b1, 5'd12, l);
    exp_q.push_back({5'd12, l});
    @(negedge clk);
    tick();
    drive_lu(1'b0, '0, '0);
    drive_alu(1'b1, 5'd0, $urandom);
    @(negedge clk);
    n_checks++;
    if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd12) begin
      n_fail++; $display("FAIL x0_alu_yields: got wen=%b x%0d, expected 1 x12", bus.rf_wen, bus.rf_waddr);
    end
    tick();
    drive_alu(1'b0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL x0_drain: got %0d outstanding, expected 0", exp_q.size()); end
  endtask

  task automatic test_stream();
    logic [REG_AW-1:0] a;
    logic [DATA_W-1:0] d;
    logic [$clog2(DEPTH):0] exp_cnt;
    for (int i = 0; i < 8; i++) begin
      tick();
      a = REG_AW'($urandom_range(1, 31));
      d = $urandom;
      drive_lu(1'b1, a, d);
      exp_q.push_back({a, d});
      exp_cnt = (i == 0) ? '0 : 2'd1;
      @(negedge clk);
      n_checks++;
      if (bus.lu_ready !== 1'b1 || bus.fifo_count !== exp_cnt) begin
        n_fail++; $display("FAIL stream i%0d: got ready=%b count=%0d, expected 1/%0d", i, bus.lu_ready, bus.fifo_count, exp_cnt);
      end
    end
    tick();
    drive_lu(1'b0, '0, '0);
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_drain: got %0d outstanding, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_flush();
    logic [DATA_W-1:0] a;
    tick();
    a = $urandom;
    bus.raddr_a = 5'd13;
    drive_alu(1'b1, 5'd2, a);
    drive_lu(1'b1, 5'd13, $urandom);
    exp_q.push_back({5'd2, a});
    @(negedge clk);
    tick();
    a = $urandom;
    drive_alu(1'b1, 5'd2, a);
    drive_lu(1'b1, 5'd14, $urandom);
    exp_q.push_back({5'd2, a});
    @(negedge clk);
    n_checks++;
    if (bus.pend_a !== 1'b1) begin n_fail++; $display("FAIL flush_pend_before: got %b, expected 1", bus.pend_a); end
    tick();
    rst = 1'b1;
    drive_idle();
    bus.raddr_a = 5'd13;
    @(negedge clk);
    n_checks++;
    if (bus.rf_wen !== 1'b0 || bus.pend_a !== 1'b0 || bus.alu_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_reset: got wen=%b pend_a=%b stall=%b, expected 0/0/0", bus.rf_wen, bus.pend_a, bus.alu_stall);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.fifo_count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d, expected 0", bus.fifo_count); end
    n_checks++;
    if (bus.pend_a !== 1'b0) begin n_fail++; $display("FAIL flush_pend_after: got %b, expected 0", bus.pend_a); end
    n_checks++;
    if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b, expected 1", bus.lu_ready); end
    tick();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_drain: got %0d outstanding, expected 0", exp_q.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_lu_single();
    test_alu_priority();
    test_starve();
    test_back_to_back();
    test_x0();
    test_stream();
    test_reset_flush();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, the number of long-latency result FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter STARVE_MAX, default 4, the number of consecutive lost arbitrations before a forced drain.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have ports alu_valid (input, 1), alu_waddr (input, 5) and alu_wdata (input, 32) carrying the single-cycle ALU writeback; there is no ready signal.
REQ-006 SHALL have port alu_stall, output, 1 bit; when high, upstream holds its ALU result and the arbiter ignores alu_valid.
REQ-007 SHALL have ports lu_valid (input, 1), lu_waddr (input, 5) and lu_wdata (input, 32) carrying long-latency (load/mul/div) results.
REQ-008 SHALL have port lu_ready, output, 1 bit, the long-latency handshake ready.
REQ-009 SHALL have ports rf_wen (output, 1), rf_waddr (output, 5) and rf_wdata (output, 32) that drive the register file write port.
REQ-010 SHALL have ports raddr_a and raddr_b (inputs, 5 each) and pend_a and pend_b (outputs, 1 each) for the pending-write hazard query.
REQ-011 SHALL have port fifo_count, output, clog2(DEPTH)+1 bits, the current FIFO occupancy.

Function
REQ-012 SHALL accept a long-latency transfer in a cycle where lu_valid and lu_ready are both high.
REQ-013 SHALL drive lu_ready equal to (fifo_count < DEPTH); lu_ready SHALL NOT depend on lu_valid, and a full FIFO does not pass entries through.
REQ-014 SHALL enqueue an accepted transfer at the FIFO tail unless lu_waddr is 0; an accepted lu_waddr=0 transfer is discarded.
REQ-015 SHALL write a long-latency result to the register file no earlier than 1 cycle after it is accepted (no bypass around the FIFO).
REQ-016 SHALL select the register-file write combinationally, in this priority order:
- alu_stall high: write the FIFO head.
- else alu_valid high and alu_waddr non-zero: write the ALU result.
- else FIFO non-empty: write the FIFO head.
- else: rf_wen = 0.
REQ-017 SHALL treat alu_valid with alu_waddr=0 as consumed with no write, which leaves the port free for the FIFO head in that cycle.
REQ-018 SHALL pop the FIFO head in any cycle where it is written; a push and a pop in the same cycle leave fifo_count unchanged.
REQ-019 SHALL hold starve_cnt, a counter that increments when the FIFO is non-empty and the ALU wins the write port, and clears on any FIFO pop.
REQ-020 SHALL assert alu_stall combinationally when starve_cnt == STARVE_MAX and the FIFO is non-empty; that cycle drains the head and clears the counter.
REQ-021 SHALL assert pend_a when raddr_a is non-zero and matches the waddr of any valid FIFO entry; pend_b SHALL behave the same for raddr_b.
REQ-022 SHALL write each FIFO entry in FIFO order; when two entries share a waddr, the last write wins.
REQ-023 SHALL keep rf_waddr and rf_wdata at 0 whenever rf_wen is 0.

Reset
REQ-024 SHALL, while rst is high, clear the FIFO pointers, fifo_count and starve_cnt, discarding any in-flight entries.
REQ-025 SHALL drive rf_wen=0, alu_stall=0 and pend_a=pend_b=0 during reset, and lu_ready=1 from the first cycle after reset.
REQ-026 SHALL NOT reset FIFO data storage.

Structure
REQ-027 SHALL place the register-address width (5), data width (32) and the x0 address constant in a shared package used by the register file and the decoder.
REQ-028 SHALL implement the FIFO as one sub-module, wb_fifo, with count and head outputs and exposed per-entry valid and waddr for the pending compare; arbitration and starvation logic stay in the top level.

Verification
REQ-029 SHALL cover: lu transfer of x5=0x11 with ALU idle -> rf_wen on the next cycle, rf_waddr=5, rf_wdata=0x11, fifo_count back to 0.
REQ-030 SHALL cover: alu_valid x3=0xA together with a queued lu x4=0xB -> ALU written first, x4 written the following cycle.
REQ-031 SHALL cover: ALU writing every cycle, FIFO holding 1 entry -> alu_stall high on the 5th cycle, head written, counter cleared.
REQ-032 SHALL cover: three back-to-back lu transfers while the ALU writes every cycle -> lu_ready low after 2 accepts, third transfer held until a pop.
REQ-033 SHALL cover: lu x0=0xFF and alu x0 -> both accepted, rf_wen never high, pend_a low for raddr_a=0.
REQ-034 SHALL cover: rst asserted with 2 entries queued -> fifo_count=0, pend_a=0 for the queued address, lu_ready=1 the next cycle.
